// File: rtl/maze_pkg.sv
// Shared maze types: move directions, replay FSM states and the direction-inversion mask.
package maze_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT,
    DONE
  } replay_state_t;

  // XOR with this mask turns a direction into its opposite.
  localparam logic [1:0] DIR_INVERT = 2'b10;

endpackage

// File: rtl/maze_step.sv
// One maze move: next cell from the current cell and direction, with an edge-of-maze flag.
// pos/next_pos are packed as {y, x}.
module maze_step
  import maze_pkg::*;
#(
  parameter  int MAZE_DIM = 16,
  localparam int CW       = $clog2(MAZE_DIM)
) (
  input  logic [2*CW-1:0] pos,
  input  dir_t            dir,
  output logic [2*CW-1:0] next_pos,
  output logic            out_of_bounds
);

  localparam logic [CW-1:0] EDGE_MAX = CW'(MAZE_DIM - 1);

  logic [CW-1:0] x, y, nx, ny;

  assign x = pos[CW-1:0];
  assign y = pos[2*CW-1:CW];

  always_comb begin
    nx            = x;
    ny            = y;
    out_of_bounds = 1'b0;
    unique case (dir)
      UP: begin
        out_of_bounds = (y == '0);
        ny            = y - CW'(1);
      end
      RIGHT: begin
        out_of_bounds = (x == EDGE_MAX);
        nx            = x + CW'(1);
      end
      DOWN: begin
        out_of_bounds = (y == EDGE_MAX);
        ny            = y + CW'(1);
      end
      LEFT: begin
        out_of_bounds = (x == '0);
        nx            = x - CW'(1);
      end
    endcase
  end

  assign next_pos = {ny, nx};

endmodule

// File: rtl/path_replayer.sv
// Walks the solver's direction stack by index and emits each move with the cell reached.
// Optional macro PATH_REVERSE_EN replays goal-to-start with inverted directions.
module path_replayer
  import maze_pkg::*;
#(
  parameter  int MAZE_DIM = 16,
  parameter  int START_X  = 0,
  parameter  int START_Y  = 0,
  parameter  int GOAL_X   = MAZE_DIM - 1,
  parameter  int GOAL_Y   = MAZE_DIM - 1,
  localparam int CW       = $clog2(MAZE_DIM)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    top,
  output logic [7:0]    rd_addr,
  input  logic [1:0]    rd_data,
  output logic          move_valid,
  input  logic          move_ready,
  output logic [1:0]    move_dir,
  output logic [CW-1:0] pos_x,
  output logic [CW-1:0] pos_y,
  output logic          busy,
  output logic          done,
  output logic          error
);

`ifdef PATH_REVERSE_EN
  localparam bit REVERSE = 1'b1;
`else
  localparam bit REVERSE = 1'b0;
`endif

  localparam logic [CW-1:0] ORIGIN_X = REVERSE ? CW'(GOAL_X) : CW'(START_X);
  localparam logic [CW-1:0] ORIGIN_Y = REVERSE ? CW'(GOAL_Y) : CW'(START_Y);
  localparam logic [1:0]    DIR_XOR  = REVERSE ? DIR_INVERT : 2'b00;

  replay_state_t state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d;
  logic [CW-1:0] px_q, px_d, py_q, py_d;
  dir_t          dir_q, dir_d;
  logic          err_q, err_d;

  dir_t          step_dir;
  logic [2*CW-1:0] step_next;
  logic          step_oob;
  logic          last_idx;

  assign step_dir = dir_t'(rd_data ^ DIR_XOR);

  maze_step #(.MAZE_DIM(MAZE_DIM)) u_step (
    .pos           ({py_q, px_q}),
    .dir           (step_dir),
    .next_pos      (step_next),
    .out_of_bounds (step_oob)
  );

  assign last_idx = REVERSE ? (idx_q == 8'd0) : (idx_q == len_q - 8'd1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    px_d    = px_q;
    py_d    = py_q;
    dir_d   = dir_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = top;
          idx_d   = REVERSE ? top - 8'd1 : 8'd0;
          px_d    = ORIGIN_X;
          py_d    = ORIGIN_Y;
          err_d   = 1'b0;
          state_d = (top == 8'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        dir_d = step_dir;
        // An illegal move aborts the replay without ever being presented.
        if (step_oob) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          {py_d, px_d} = step_next;
          state_d      = EMIT;
        end
      end
      EMIT: begin
        if (move_ready) begin
          if (last_idx) begin
            state_d = DONE;
          end else begin
            idx_d   = REVERSE ? idx_q - 8'd1 : idx_q + 8'd1;
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      px_q    <= CW'(START_X);
      py_q    <= CW'(START_Y);
      dir_q   <= UP;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      px_q    <= px_d;
      py_q    <= py_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign rd_addr    = idx_q;
  assign move_valid = (state_q == EMIT);
  assign move_dir   = dir_q;
  assign pos_x      = px_q;
  assign pos_y      = py_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign error      = err_q;

endmodule

// File: doc/path_replayer.md
# path_replayer

Downstream consumer of the Binary Maze direction stack. Once the solver has finished pushing moves, this block walks the stack contents by index and emits the solved path one move at a time, with the maze coordinate reached after each move, over a valid/ready handshake to the display/output stage. It reads the stack through an address/data port and never pushes to or pops from it.

## Interface

Parameters:
- `MAZE_DIM`, default 16: maze side length in cells. Coordinate width is `CW = $clog2(MAZE_DIM)`.
- `START_X`, default 0: start-cell column.
- `START_Y`, default 0: start-cell row.
- `GOAL_X`, default `MAZE_DIM-1`: goal-cell column. Used only with `PATH_REVERSE_EN`.
- `GOAL_Y`, default `MAZE_DIM-1`: goal-cell row. Used only with `PATH_REVERSE_EN`.

Ports:
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: begin a replay. Sampled only in IDLE.
- `top` input 8: stack depth (number of stored moves). Sampled at start.
- `rd_addr` output 8: stack read index.
- `rd_data` input 2: stack entry at `rd_addr`, combinational, same cycle.
- `move_valid` output 1: a move is presented.
- `move_ready` input 1: the consumer accepts the move.
- `move_dir` output 2: direction of the presented move.
- `pos_x`, `pos_y` output CW: position after the presented move.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: one-cycle pulse at the end of a replay.
- `error` output 1: a move would leave the maze. Sticky until the next accepted `start` or `reset`.

## Operation

Direction encoding:
- 00 = up (y-1)
- 01 = right (x+1)
- 10 = down (y+1)
- 11 = left (x-1)

FSM states: IDLE, FETCH, EMIT, DONE.

- **IDLE**
  - On `start`: latch `len = top`, set `idx = 0`, `pos = (START_X, START_Y)`, clear `error`.
  - If `len == 0`, go to DONE; otherwise go to FETCH.
- **FETCH**
  - Drive `rd_addr = idx`.
  - Register `dir = rd_data` and compute `next_pos`.
  - If the move is out of bounds (x or y below 0 or above `MAZE_DIM-1`): set `error` and go to DONE. Nothing is emitted for that move.
  - Otherwise load `pos = next_pos` and go to EMIT.
- **EMIT**
  - `move_valid = 1`; `move_dir` and `pos_x`/`pos_y` are stable while valid.
  - On `move_valid && move_ready`: if `idx == len-1`, go to DONE; else `idx++` and go to FETCH.
  - Valid is never withdrawn without acceptance.
- **DONE**
  - `done = 1` for this single cycle, then go to IDLE.

Other rules:
- `start` while busy is ignored.
- `top` and stack contents must be held stable by upstream during a replay; changes are not tracked.
- `len = 255` (stack full) is legal; `idx` never wraps.
- Reset at any time, including mid-EMIT, forces IDLE immediately. The pending move is dropped.

## Timing

- Reset values:
  - `move_valid`, `busy`, `done`, `error` = 0
  - `rd_addr` = 0
  - `move_dir` = 0
  - `pos_x` = `START_X`, `pos_y` = `START_Y`
- Latency: `start` at edge N gives FETCH in cycle N+1 and `move_valid` high in cycle N+2.
- Throughput: one move per 2 cycles with `move_ready` held high.
- Zero-length path: `done` is high in cycle N+1.
- Last acceptance at edge M gives `done` high in cycle M+1, and `busy` low from cycle M+2.
- All outputs are registered, except `rd_addr`, which is decoded from `idx`.

## Configuration

- `PATH_REVERSE_EN` defined:
  - Replay goal-to-start: `idx` starts at `len-1` and decrements.
  - Each direction is inverted (XOR 2'b10).
  - Start position is `(GOAL_X, GOAL_Y)`.
  - Terminates after index 0 is accepted.
- `PATH_REVERSE_EN` undefined: forward order only. `GOAL_X`/`GOAL_Y` are unused.

## Structure

- Package `maze_pkg`:
  - `dir_t` enum (UP, RIGHT, DOWN, LEFT)
  - `replay_state_t`
  - `DIR_INVERT` constant 2'b10
- Sub-module `maze_step` (combinational):
  - Inputs: `pos` and `dir`.
  - Outputs: `next_pos` and `out_of_bounds`.
  - Shared with the solver.

## Test plan

- Stack [01,01,10], `top=3`, `move_ready` held 1 -> moves (1,0), (2,0), (2,1) at cycles N+2, N+4, N+6; `done` pulses at N+7; `error` stays 0.
- `top=0`, `start` -> `done` at N+1; `move_valid` never asserts.
- Stack [00] from (0,0) -> no `move_valid`; `error=1`; `done` pulses; `error` clears on the next `start`.
- Backpressure: `move_ready=0` for 5 cycles on move 2 -> `move_valid`, `move_dir` and pos held constant; no move skipped or duplicated.
- `reset` asserted mid-EMIT of move 2 of 4 -> same cycle: `busy=0`, `move_valid=0`, pos=(0,0); the next `start` replays from idx 0.
- With `PATH_REVERSE_EN`, stack [01,10], goal (1,1) -> moves UP to (1,0), then LEFT to (0,0); `done` follows.
